ddr3_bridge: RTL and testbench

Parametrised bridge from the core's narrow single-word memory port to the DDR3 controller's wide Avalon-MM local interface. Narrow requests are registered in a one-entry request stage. Each one is issued as a size-1 Avalon command with correct burstbegin framing. Read lane indices are tracked in a tag FIFO so each returning wide beat is narrowed back to the requested word. The block sits between the system interconnect and the DDR3 controller IP, replacing the previous combinational narrow/wide adapter.

---
 rtl/ddr3_bridge_if.sv | 49 ++++
 rtl/ddr3_bridge.sv | 162 ++++++++++++++++
 tb/tb_ddr3_bridge.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_bridge_if.sv
// Signal bundle between the core's narrow memory port, the bridge and the DDR3 controller's Avalon-MM local port.
// Handshake: a core request transfers on a cycle where read_req/write_req and ready are both high; an Avalon command transfers on a cycle where avl_read_req/avl_write_req and avl_ready are both high, and it is held stable until then.
interface ddr3_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 25
);
  localparam int LANE_W  = $clog2(RATIO);
  localparam int WADDR_W = ADDR_WIDTH - LANE_W;
  localparam int BE_W    = DATA_WIDTH / 8;

  logic                          ready;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [DATA_WIDTH-1:0]         write_data;
  logic [BE_W-1:0]               byte_enable;
  logic                          write_req;
  logic                          read_req;
  logic [DATA_WIDTH-1:0]         read_data;
  logic                          read_data_valid;

  logic                          avl_ready;
  logic                          avl_burstbegin;
  logic [WADDR_W-1:0]            avl_addr;
  logic                          avl_rdata_valid;
  logic [DATA_WIDTH*RATIO-1:0]   avl_rdata;
  logic [DATA_WIDTH*RATIO-1:0]   avl_wdata;
  logic [BE_W*RATIO-1:0]         avl_be;
  logic                          avl_read_req;
  logic                          avl_write_req;
  logic [6:0]                    avl_size;

  // Bridge view.
  modport slave (
    output ready, read_data, read_data_valid,
    input  addr, write_data, byte_enable, write_req, read_req,
    input  avl_ready, avl_rdata_valid, avl_rdata,
    output avl_burstbegin, avl_addr, avl_wdata, avl_be,
    output avl_read_req, avl_write_req, avl_size
  );

  // Surroundings view: core requester plus controller responder.
  modport master (
    input  ready, read_data, read_data_valid,
    output addr, write_data, byte_enable, write_req, read_req,
    output avl_ready, avl_rdata_valid, avl_rdata,
    input  avl_burstbegin, avl_addr, avl_wdata, avl_be,
    input  avl_read_req, avl_write_req, avl_size
  );
endinterface

// File: rtl/ddr3_bridge.sv
// Narrow-to-wide DDR3 Avalon-MM bridge: one-entry request stage, size-1 commands, tag FIFO narrowing read beats.
// Optional macro DDR3_BRIDGE_READ_REG_EN registers read_data/read_data_valid (one extra cycle of return latency).
module ddr3_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int RATIO          = 2,
  parameter int ADDR_WIDTH     = 25,
  parameter int TAG_DEPTH_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  ddr3_bridge_if.slave              bus,
  output logic                      dbg_state_o,
  output logic [TAG_DEPTH_BITS:0]   dbg_rd_count_o
);
  localparam int LANE_W  = $clog2(RATIO);
  localparam int WADDR_W = ADDR_WIDTH - LANE_W;
  localparam int WIDE_W  = DATA_WIDTH * RATIO;
  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int WBE_W   = BE_W * RATIO;
  localparam int DEPTH   = 1 << TAG_DEPTH_BITS;

  localparam logic [TAG_DEPTH_BITS:0]   DEPTH_CNT = (TAG_DEPTH_BITS+1)'(DEPTH);
  localparam logic [TAG_DEPTH_BITS:0]   CNT_ONE   = {{TAG_DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [TAG_DEPTH_BITS-1:0] PTR_ONE   = {{(TAG_DEPTH_BITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic                       first_q, first_d;
  logic                       is_write_q, is_write_d;
  logic [WADDR_W-1:0]         avl_addr_q, avl_addr_d;
  logic [WIDE_W-1:0]          avl_wdata_q, avl_wdata_d;
  logic [WBE_W-1:0]           avl_be_q, avl_be_d;
  logic [TAG_DEPTH_BITS:0]    rd_count_q, rd_count_d;
  logic [TAG_DEPTH_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [TAG_DEPTH_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0]          tag_mem [DEPTH];

  logic                       req_valid;
  logic                       rd_room;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic [LANE_W-1:0]          lane;
  logic [LANE_W-1:0]          rd_tag;
  logic [DATA_WIDTH-1:0]      rdata_narrow;

  assign req_valid = (state_q == ST_HELD);
  assign lane      = bus.addr[LANE_W-1:0];

  // The tag-room term gates writes too, so ready never depends on request type.
  assign rd_room   = (rd_count_q < DEPTH_CNT);
  assign bus.ready = (!req_valid || bus.avl_ready) && rd_room;
  assign accept    = bus.ready && (bus.read_req || bus.write_req);

  // Write wins over a simultaneous (illegal) read; the read leaves no tag.
  assign push = accept && bus.read_req && !bus.write_req;
  assign pop  = bus.avl_rdata_valid && (rd_count_q != '0);

  always_comb begin
    state_d     = state_q;
    first_d     = 1'b0;
    is_write_d  = is_write_q;
    avl_addr_d  = avl_addr_q;
    avl_wdata_d = avl_wdata_q;
    avl_be_d    = avl_be_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_HELD;
      ST_HELD:  if (bus.avl_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    // Accept only happens when the stage is free or being drained this cycle.
    if (accept) begin
      first_d     = 1'b1;
      is_write_d  = bus.write_req;
      avl_addr_d  = bus.addr[ADDR_WIDTH-1:LANE_W];
      avl_wdata_d = '0;
      avl_wdata_d[lane*DATA_WIDTH +: DATA_WIDTH] = bus.write_data;
      avl_be_d    = '0;
      avl_be_d[lane*BE_W +: BE_W] = bus.byte_enable;
    end
  end

  always_comb begin
    rd_count_d = rd_count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push && !pop) rd_count_d = rd_count_q + CNT_ONE;
    if (pop && !push) rd_count_d = rd_count_q - CNT_ONE;
    if (push)         wr_ptr_d   = wr_ptr_q + PTR_ONE;
    if (pop)          rd_ptr_d   = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      first_q     <= 1'b0;
      is_write_q  <= 1'b0;
      avl_addr_q  <= '0;
      avl_wdata_q <= '0;
      avl_be_q    <= '0;
      rd_count_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      is_write_q  <= is_write_d;
      avl_addr_q  <= avl_addr_d;
      avl_wdata_q <= avl_wdata_d;
      avl_be_q    <= avl_be_d;
      rd_count_q  <= rd_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= lane;
  end

  // A stray beat with no outstanding tag is narrowed from lane 0.
  assign rd_tag       = (rd_count_q != '0) ? tag_mem[rd_ptr_q] : '0;
  assign rdata_narrow = bus.avl_rdata[rd_tag*DATA_WIDTH +: DATA_WIDTH];

`ifdef DDR3_BRIDGE_READ_REG_EN
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  read_data_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q       <= '0;
      read_data_valid_q <= 1'b0;
    end else begin
      read_data_q       <= rdata_narrow;
      read_data_valid_q <= bus.avl_rdata_valid;
    end
  end

  assign bus.read_data       = read_data_q;
  assign bus.read_data_valid = read_data_valid_q;
`else
  assign bus.read_data       = rdata_narrow;
  assign bus.read_data_valid = bus.avl_rdata_valid;
`endif

  assign bus.avl_burstbegin = req_valid && first_q;
  assign bus.avl_read_req   = req_valid && !is_write_q;
  assign bus.avl_write_req  = req_valid && is_write_q;
  assign bus.avl_addr       = avl_addr_q;
  assign bus.avl_wdata      = avl_wdata_q;
  assign bus.avl_be         = avl_be_q;
  assign bus.avl_size       = 7'd1;

  assign dbg_state_o    = state_q;
  assign dbg_rd_count_o = rd_count_q;
endmodule

// File: tb/tb_ddr3_bridge.sv
// Directed bench for ddr3_bridge: a RATIO=2 instance for the main sequences and a RATIO=4 instance for lane slicing.
module tb_ddr3_bridge;
  localparam int DW  = 32;
  localparam int AW  = 25;
  localparam int TDB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ddr3_bridge_if #(.DATA_WIDTH(DW), .RATIO(2), .ADDR_WIDTH(AW)) bus2 ();
  ddr3_bridge_if #(.DATA_WIDTH(DW), .RATIO(4), .ADDR_WIDTH(AW)) bus4 ();

  logic           st2, st4;
  logic [TDB:0]   cnt2, cnt4;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];
  logic [1:0] exp4_q[$];

  ddr3_bridge #(.DATA_WIDTH(DW), .RATIO(2), .ADDR_WIDTH(AW), .TAG_DEPTH_BITS(TDB)) u_dut2 (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus2),
    .dbg_state_o    (st2),
    .dbg_rd_count_o (cnt2)
  );

  ddr3_bridge #(.DATA_WIDTH(DW), .RATIO(4), .ADDR_WIDTH(AW), .TAG_DEPTH_BITS(TDB)) u_dut4 (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus4),
    .dbg_state_o    (st4),
    .dbg_rd_count_o (cnt4)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic idle_all();
    bus2.addr = '0; bus2.write_data = '0; bus2.byte_enable = '0;
    bus2.write_req = 1'b0; bus2.read_req = 1'b0;
    bus2.avl_ready = 1'b1; bus2.avl_rdata_valid = 1'b0; bus2.avl_rdata = '0;
    bus4.addr = '0; bus4.write_data = '0; bus4.byte_enable = '0;
    bus4.write_req = 1'b0; bus4.read_req = 1'b0;
    bus4.avl_ready = 1'b1; bus4.avl_rdata_valid = 1'b0; bus4.avl_rdata = '0;
  endtask

  task automatic rd2(input logic [AW-1:0] a);
    bus2.addr = a; bus2.read_req = 1'b1; bus2.write_req = 1'b0;
    exp_q.push_back({1'b0, a[0]});
  endtask

  task automatic ret2(input string tag, input logic [63:0] data);
    logic [1:0] ln;
    bus2.avl_rdata = data; bus2.avl_rdata_valid = 1'b1;
    #1;
    ln = exp_q.pop_front();
    check(tag, bus2.read_data, ln[0] ? data[63:32] : data[31:0]);
    check({tag, "_vld"}, bus2.read_data_valid, 1'b1);
  endtask

  task automatic ret4(input string tag, input logic [127:0] data);
    logic [1:0] ln;
    bus4.avl_rdata = data; bus4.avl_rdata_valid = 1'b1;
    #1;
    ln = exp4_q.pop_front();
    check(tag, bus4.read_data, data[ln*32 +: 32]);
  endtask

  initial begin
    idle_all();
    repeat (3) step();

    // Reset values
    check("rst_ready", bus2.ready, 1'b1);
    check("rst_rreq", bus2.avl_read_req, 1'b0);
    check("rst_wreq", bus2.avl_write_req, 1'b0);
    check("rst_bb", bus2.avl_burstbegin, 1'b0);
    check("rst_addr", bus2.avl_addr, 24'h0);
    check("rst_wdata", bus2.avl_wdata, 64'h0);
    check("rst_be", bus2.avl_be, 8'h0);
    check("rst_rvld", bus2.read_data_valid, 1'b0);
    check("rst_size", bus2.avl_size, 7'd1);
    check("rst_cnt", cnt2, 5'd0);
    reset = 1'b0;

    // Single write to lane 1
    bus2.addr = 25'h3; bus2.write_data = 32'hDEADBEEF; bus2.byte_enable = 4'hF; bus2.write_req = 1'b1;
    #1 check("wr_ready", bus2.ready, 1'b1);
    step();
    bus2.write_req = 1'b0;
    check("wr_wreq", bus2.avl_write_req, 1'b1);
    check("wr_rreq", bus2.avl_read_req, 1'b0);
    check("wr_bb", bus2.avl_burstbegin, 1'b1);
    check("wr_addr", bus2.avl_addr, 24'h1);
    check("wr_wdata", bus2.avl_wdata, 64'hDEADBEEF_00000000);
    check("wr_be", bus2.avl_be, 8'hF0);
    step();
    check("wr_done", bus2.avl_write_req, 1'b0);

    // Read lane 1, zero-latency return
    rd2(25'h5);
    step();
    bus2.read_req = 1'b0;
    check("rd_rreq", bus2.avl_read_req, 1'b1);
    check("rd_bb", bus2.avl_burstbegin, 1'b1);
    check("rd_addr", bus2.avl_addr, 24'h2);
    check("rd_cnt1", cnt2, 5'd1);
    ret2("rd_data", 64'h11112222_33334444);
    step();
    bus2.avl_rdata_valid = 1'b0;
    #1 check("rd_vld_off", bus2.read_data_valid, 1'b0);
    check("rd_cnt0", cnt2, 5'd0);

    // Write and read together: write wins, no tag
    bus2.addr = 25'h7; bus2.write_data = 32'h12345678; bus2.byte_enable = 4'h3;
    bus2.write_req = 1'b1; bus2.read_req = 1'b1;
    step();
    bus2.write_req = 1'b0; bus2.read_req = 1'b0;
    check("both_wreq", bus2.avl_write_req, 1'b1);
    check("both_rreq", bus2.avl_read_req, 1'b0);
    check("both_cnt", cnt2, 5'd0);
    check("both_wdata", bus2.avl_wdata, 64'h12345678_00000000);
    check("both_be", bus2.avl_be, 8'h30);
    step();

    // Stall three cycles while HELD
    rd2(25'h8);
    step();
    bus2.read_req = 1'b0; bus2.avl_ready = 1'b0;
    #1;
    check("stl1_rreq", bus2.avl_read_req, 1'b1);
    check("stl1_bb", bus2.avl_burstbegin, 1'b1);
    check("stl1_addr", bus2.avl_addr, 24'h4);
    check("stl1_ready", bus2.ready, 1'b0);
    step();
    check("stl2_rreq", bus2.avl_read_req, 1'b1);
    check("stl2_bb", bus2.avl_burstbegin, 1'b0);
    check("stl2_addr", bus2.avl_addr, 24'h4);
    step();
    check("stl3_rreq", bus2.avl_read_req, 1'b1);
    check("stl3_bb", bus2.avl_burstbegin, 1'b0);
    check("stl3_ready", bus2.ready, 1'b0);
    bus2.avl_ready = 1'b1;
    step();
    check("stl_done", bus2.avl_read_req, 1'b0);
    check("stl_cnt", cnt2, 5'd1);
    ret2("stl_data", 64'hAAAABBBB_CCCCDDDD);
    step();
    bus2.avl_rdata_valid = 1'b0;
    check("stl_cnt0", cnt2, 5'd0);

    // Fill the tag FIFO
    for (int i = 0; i < 16; i++) begin
      #1 check("fill_ready", bus2.ready, 1'b1);
      rd2(25'(i));
      step();
    end
    bus2.read_req = 1'b0;
    #1;
    check("full_cnt", cnt2, 5'd16);
    check("full_ready", bus2.ready, 1'b0);
    bus2.addr = 25'h11; bus2.read_req = 1'b1;
    ret2("full_ret", 64'hA0000001_B0000000);
    step();
    check("full_cnt15", cnt2, 5'd15);
    exp_q.push_back(2'd1);
    ret2("sim_ret", 64'hA0000002_B0000002);
    step();
    bus2.read_req = 1'b0;
    check("sim_cnt", cnt2, 5'd15);
    for (int k = 0; k < 15; k++) begin
      ret2("drain", {32'hC0000000 | 32'(k), 32'hD0000000 | 32'(k)});
      step();
    end
    bus2.avl_rdata_valid = 1'b0;
    #1;
    check("drain_cnt", cnt2, 5'd0);
    check("drain_ready", bus2.ready, 1'b1);

    // RATIO=4 lane slicing: lanes 3, 0, 2
    bus4.read_req = 1'b1;
    bus4.addr = 25'h3; exp4_q.push_back(2'd3); step();
    bus4.addr = 25'h4; exp4_q.push_back(2'd0); step();
    bus4.addr = 25'h6; exp4_q.push_back(2'd2); step();
    bus4.read_req = 1'b0;
    check("r4_cnt", cnt4, 5'd3);
    ret4("r4_lane3", 128'h44444444_33333333_22222222_11111111); step();
    ret4("r4_lane0", 128'h44444444_33333333_22222222_11111111); step();
    ret4("r4_lane2", 128'h44444444_33333333_22222222_11111111); step();
    bus4.avl_rdata_valid = 1'b0;
    check("r4_cnt0", cnt4, 5'd0);

    // Reset while HELD with two outstanding reads
    rd2(25'h0); step();
    rd2(25'h1); step();
    bus2.read_req = 1'b0; bus2.avl_ready = 1'b0;
    #1 check("mid_cnt2", cnt2, 5'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rreq", bus2.avl_read_req, 1'b0);
    check("mid_wreq", bus2.avl_write_req, 1'b0);
    check("mid_ready", bus2.ready, 1'b1);
    check("mid_cnt", cnt2, 5'd0);
    bus2.avl_rdata = 64'h11111111_22222222; bus2.avl_rdata_valid = 1'b1;
    #1 check("stray_data", bus2.read_data, 32'h22222222);
    step();
    bus2.avl_rdata_valid = 1'b0;
    check("stray_cnt", cnt2, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
